// File: rtl/phase_scheduler.sv
// One-hot phase sequencer: HALT -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK.
// Define ROCKWAVE_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  HALT      | parked, waiting for run_req without halt_req
//  FETCH     | fetch stage enabled, holds while stall_fetch
//  DECODE    | decode stage enabled, holds while stall_decode
//  EXECUTE   | execute stage enabled, holds while stall_execute
//  MEMORY    | memory stage enabled, holds while stall_memory
//  WRITEBACK | writeback enabled; completion picks FETCH or HALT
module phase_scheduler #(
    parameter int CNTLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              stall_fetch,
    input  logic              stall_decode,
    input  logic              stall_execute,
    input  logic              stall_memory,
    input  logic              stall_writeback,
    output logic              phase_fetch,
    output logic              phase_decode,
    output logic              phase_execute,
    output logic              phase_memory,
    output logic              phase_writeback,
    output logic              halted,
    output logic              retire,
    output logic [CNTLEN-1:0] instret
);

    typedef enum logic [5:0] {
        S_HALT      = 6'b000001,
        S_FETCH     = 6'b000010,
        S_DECODE    = 6'b000100,
        S_EXECUTE   = 6'b001000,
        S_MEMORY    = 6'b010000,
        S_WRITEBACK = 6'b100000
    } state_t;

    state_t state_q, state_d;
    logic   halt_pending_q, halt_pending_d;
    logic   retire_q, retire_d;
    logic   complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_HALT;
            halt_pending_q <= 1'b0;
            retire_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            retire_q       <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            S_HALT:      if (run_req && !halt_req) state_d = S_FETCH;
            S_FETCH:     if (!stall_fetch)         state_d = S_DECODE;
            S_DECODE:    if (!stall_decode)        state_d = S_EXECUTE;
            S_EXECUTE:   if (!stall_execute)       state_d = S_MEMORY;
            S_MEMORY:    if (!stall_memory)        state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                if (!stall_writeback) begin
                    complete = 1'b1;
                    state_d  = (halt_pending_q || halt_req) ? S_HALT : S_FETCH;
                end
            end
            default:     state_d = S_HALT;
        endcase

        // Leaving HALT requires halt_req=0, so a request seen in HALT never sets the flag.
        halt_pending_d = halt_pending_q;
        if (state_d == S_HALT)
            halt_pending_d = 1'b0;
        else if (halt_req)
            halt_pending_d = 1'b1;

        retire_d = complete;
    end

    assign phase_fetch     = (state_q == S_FETCH);
    assign phase_decode    = (state_q == S_DECODE);
    assign phase_execute   = (state_q == S_EXECUTE);
    assign phase_memory    = (state_q == S_MEMORY);
    assign phase_writeback = (state_q == S_WRITEBACK);
    assign halted          = (state_q == S_HALT);
    assign retire          = retire_q;

`ifdef ROCKWAVE_INSTRET_EN
    logic [CNTLEN-1:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret_q <= '0;
        else if (complete)
            instret_q <= instret_q + CNTLEN'(1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: a cycle model pushes expected outputs to a queue,
// which are popped and compared after each rising edge.
module tb_phase_scheduler;

`ifdef ROCKWAVE_INSTRET_EN
    localparam bit INSTRET_EN = 1'b1;
`else
    localparam bit INSTRET_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       run_req, halt_req;
    logic       stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback;
    logic       phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback;
    logic       halted, retire;
    logic [3:0] instret;

    phase_scheduler #(.CNTLEN(4)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .stall_memory(stall_memory),
        .stall_writeback(stall_writeback),
        .phase_fetch(phase_fetch), .phase_decode(phase_decode),
        .phase_execute(phase_execute), .phase_memory(phase_memory),
        .phase_writeback(phase_writeback),
        .halted(halted), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] ph;
        logic       halted;
        logic       retire;
        logic [3:0] instret;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // model: 0 = HALT, 1..5 = FETCH..WRITEBACK
    int   m_st  = 0;
    bit   m_hp  = 1'b0;
    int   m_cnt = 0;

    int   cyc = 0;
    int   n_ret = 0;
    int   n_exec = 0;
    int   last_ret_cyc = 0;
    int   last_gap = 0;
    bit   wrapped = 1'b0;
    logic [3:0] prev_instret = 4'd0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_hp  = 1'b0;
        m_cnt = 0;
        prev_instret = 4'd0;
    endtask

    // stalls: bit0 fetch, bit1 decode, bit2 execute, bit3 memory, bit4 writeback
    task automatic step(input string tag, input logic run, input logic hreq, input logic [4:0] st);
        exp_t e;
        int   nst;
        bit   done;
        run_req  = run;
        halt_req = hreq;
        {stall_writeback, stall_memory, stall_execute, stall_decode, stall_fetch} = st;

        nst  = m_st;
        done = 1'b0;
        if (m_st == 0) begin
            if (run && !hreq) nst = 1;
        end else if (!st[m_st-1]) begin
            if (m_st == 5) begin
                done = 1'b1;
                nst  = (m_hp || hreq) ? 0 : 1;
            end else begin
                nst = m_st + 1;
            end
        end
        if (m_st != 0 && nst == 0)      m_hp = 1'b0;
        else if (m_st != 0 && hreq)     m_hp = 1'b1;
        m_st = nst;
        if (done) m_cnt = (m_cnt + 1) % 16;

        e.ph      = (m_st == 0) ? 5'b0 : 5'(1 << (m_st - 1));
        e.halted  = (m_st == 0);
        e.retire  = done;
        e.instret = INSTRET_EN ? 4'(m_cnt) : 4'd0;
        q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = q.pop_front();
        chk({tag, ".phase"}, 8'({phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch}), 8'(e.ph));
        chk({tag, ".halted"}, 8'(halted), 8'(e.halted));
        chk({tag, ".retire"}, 8'(retire), 8'(e.retire));
        chk({tag, ".instret"}, 8'(instret), 8'(e.instret));

        if (retire) begin
            n_ret++;
            last_gap     = cyc - last_ret_cyc;
            last_ret_cyc = cyc;
        end
        if (phase_execute) n_exec++;
        if (prev_instret == 4'd15 && instret == 4'd0) wrapped = 1'b1;
        prev_instret = instret;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".halted"}, 8'(halted), 8'd1);
        chk({tag, ".phase"}, 8'({phase_writeback, phase_memory, phase_execute, phase_decode, phase_fetch}), 8'd0);
        chk({tag, ".retire"}, 8'(retire), 8'd0);
        chk({tag, ".instret"}, 8'(instret), 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        run_req = 1'b0; halt_req = 1'b0;
        stall_fetch = 1'b0; stall_decode = 1'b0; stall_execute = 1'b0;
        stall_memory = 1'b0; stall_writeback = 1'b0;
        #3;
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // three unstalled back-to-back instructions
        step("idle", 1'b0, 1'b0, 5'b0);
        step("run", 1'b1, 1'b0, 5'b0);
        for (int i = 0; i < 15; i++) step("b2b", 1'b0, 1'b0, 5'b0);
        chk("b2b.retires", 8'(n_ret), 8'd3);
        chk("b2b.gap", 8'(last_gap), 8'd5);
        if (INSTRET_EN) chk("b2b.instret3", 8'(instret), 8'd3);
        else            chk("b2b.instret0", 8'(instret), 8'd0);

        // execute stalled 4 cycles, fetch stall asserted meanwhile (ignored)
        n_exec = 0;
        step("st.f", 1'b0, 1'b0, 5'b00000);
        step("st.d", 1'b0, 1'b0, 5'b00001);
        for (int i = 0; i < 4; i++) step("st.e", 1'b0, 1'b0, 5'b00101);
        step("st.e_go", 1'b0, 1'b0, 5'b00001);
        step("st.m", 1'b0, 1'b0, 5'b00001);
        step("st.w", 1'b0, 1'b0, 5'b00000);
        chk("stall.exec_cycles", 8'(n_exec), 8'd5);
        chk("stall.instr_cycles", 8'(last_gap), 8'd9);
        chk("stall.in_fetch", 8'(phase_fetch), 8'd1);

        // halt_req pulsed in DECODE: instruction finishes, then park
        step("hd.f", 1'b0, 1'b0, 5'b0);
        step("hd.d", 1'b0, 1'b1, 5'b0);
        step("hd.e", 1'b0, 1'b0, 5'b0);
        step("hd.m", 1'b0, 1'b0, 5'b0);
        step("hd.w", 1'b0, 1'b0, 5'b0);
        chk("hd.retire_halt", 8'({retire, halted}), 8'b11);
        step("hd.park", 1'b0, 1'b0, 5'b0);
        step("hd.park", 1'b0, 1'b0, 5'b0);
        chk("hd.no_fetch", 8'(phase_fetch), 8'd0);
        step("hd.resume", 1'b1, 1'b0, 5'b0);
        chk("hd.resume_fetch", 8'(phase_fetch), 8'd1);
        for (int i = 0; i < 5; i++) step("hd.next", 1'b0, 1'b0, 5'b0);
        chk("hd.no_early_halt", 8'(halted), 8'd0);

        // halt_req in the final WRITEBACK cycle, with writeback stalled one cycle first
        for (int i = 0; i < 4; i++) step("hw.fdem", 1'b0, 1'b0, 5'b0);
        step("hw.wstall", 1'b0, 1'b0, 5'b10000);
        step("hw.wlast", 1'b0, 1'b1, 5'b0);
        chk("hw.halted", 8'(halted), 8'd1);

        // run+halt together in HALT stays; halt alone in HALT is ignored
        step("rh.both", 1'b1, 1'b1, 5'b0);
        chk("rh.stay", 8'(halted), 8'd1);
        step("rh.halt_only", 1'b0, 1'b1, 5'b0);
        step("rh.run", 1'b1, 1'b0, 5'b0);
        chk("rh.fetch", 8'(phase_fetch), 8'd1);
        for (int i = 0; i < 5; i++) step("rh.instr", 1'b0, 1'b0, 5'b0);
        chk("rh.no_halt", 8'(phase_fetch), 8'd1);

        // async reset mid-MEMORY with halt pending
        step("rm.f", 1'b0, 1'b1, 5'b0);
        step("rm.d", 1'b0, 1'b0, 5'b0);
        step("rm.e", 1'b0, 1'b0, 5'b0);
        chk("rm.in_mem", 8'(phase_memory), 8'd1);
        #1;
        rst = 1'b1;
        #2;
        chk_reset_vals("rm.async");
        #1;
        rst = 1'b0;
        model_reset();
        n_ret   = 0;
        wrapped = 1'b0;

        // 17 instructions after reset: counter wraps 15 -> 0 and ends at 1
        step("wr.run", 1'b1, 1'b0, 5'b0);
        for (int i = 0; i < 5; i++) step("wr.first", 1'b0, 1'b0, 5'b0);
        chk("rm.no_early_halt", 8'(halted), 8'd0);
        for (int i = 0; i < 80; i++) step("wr", 1'b0, 1'b0, 5'b0);
        chk("wr.retires", 8'(n_ret), 8'd17);
        if (INSTRET_EN) begin
            chk("wr.wrapped", 8'(wrapped), 8'd1);
            chk("wr.final", 8'(instret), 8'd1);
        end else begin
            chk("wr.final0", 8'(instret), 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
